// File: rtl/touch_pad_reader.sv
// touch_pad_reader
//   Samples raw touch pad levels, synchronises them through two flops,
//   debounces each pad with its own counter and turns every accepted
//   level change into a press/release event on a valid/ready port.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   pad_i      raw asynchronous pad levels, 1 = touched
//   state_o    debounced pad levels
//   evt_valid  event available
//   evt_ready  consumer accepts the presented event
//   evt_pad    index of the pad that changed
//   evt_press  1 = press (0->1), 0 = release (1->0)
//   overflow_o sticky: an event was merged into an undelivered one
//   ovf_clear  clears overflow_o (a simultaneous set wins)
module touch_pad_reader #(
    parameter int NUM_PADS        = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] pad_i,
    output logic [NUM_PADS-1:0] state_o,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_pad,
    output logic                evt_press,
    output logic                overflow_o,
    input  logic                ovf_clear
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic [NUM_PADS-1:0] state_q, state_d;
    logic [NUM_PADS-1:0] pend_q, pend_d;
    logic [NUM_PADS-1:0] kind_q, kind_d;
    logic [NUM_PADS-1:0] flip, drain;
    logic [CNT_W-1:0]    cnt_q [NUM_PADS];
    logic [CNT_W-1:0]    cnt_d [NUM_PADS];

    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] evt_pad_q, evt_pad_d;
    logic             evt_press_q, evt_press_d;
    logic             ovf_q, ovf_d;

    logic             load;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;

    // Debounce: any cycle where the synchronised level agrees with the
    // accepted level restarts the count, so only an unbroken run flips.
    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            flip[i]  = 1'b0;
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    flip[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        state_d = state_q ^ flip;
    end

    // The output register refills whenever it is empty or being consumed.
    // Descending scan so the lowest pending index wins.
    always_comb begin
        load      = !evt_valid_q || evt_ready;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PADS; i++) begin
            drain[i] = load && sel_found && (sel_idx == IDX_W'(i));
        end
    end

    // A flip on the pad being drained re-arms it rather than merging.
    always_comb begin
        pend_d = (pend_q & ~drain) | flip;
        kind_d = (kind_q & ~flip) | (state_d & flip);

        evt_valid_d = evt_valid_q;
        evt_pad_d   = evt_pad_q;
        evt_press_d = evt_press_q;
        if (load) begin
            evt_valid_d = sel_found;
            if (sel_found) begin
                evt_pad_d   = sel_idx;
                evt_press_d = kind_q[sel_idx];
            end
        end

        ovf_d = ovf_q;
        if (ovf_clear) begin
            ovf_d = 1'b0;
        end
        if (|(flip & pend_q & ~drain)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= '0;
            pend_q      <= '0;
            kind_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_pad_q   <= '0;
            evt_press_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= pad_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            pend_q      <= pend_d;
            kind_q      <= kind_d;
            evt_valid_q <= evt_valid_d;
            evt_pad_q   <= evt_pad_d;
            evt_press_q <= evt_press_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign state_o    = state_q;
    assign evt_valid  = evt_valid_q;
    assign evt_pad    = evt_pad_q;
    assign evt_press  = evt_press_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_touch_pad_reader.sv
module tb_touch_pad_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pad_i;
    logic [3:0] state_o;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_pad;
    logic       evt_press;
    logic       overflow_o;
    logic       ovf_clear;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q [$];  // {pad, press}

    logic       hold_q = 1'b0;
    logic [1:0] hold_pad;
    logic       hold_press;

    always #5 clk = ~clk;

    touch_pad_reader #(
        .NUM_PADS(4), .IDX_W(2), .DEBOUNCE_CYCLES(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .pad_i(pad_i), .state_o(state_o),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_pad(evt_pad),
        .evt_press(evt_press), .overflow_o(overflow_o), .ovf_clear(ovf_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] pad, input logic press);
        exp_q.push_back({pad, press});
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_pad"}, 32'(evt_pad), 32'd0);
        check({tag, "_press"}, 32'(evt_press), 32'd0);
        check({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    endtask

    // Scoreboard monitor: pops on every handshake, and checks that a
    // stalled event is held unchanged.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!rst) begin
            if (hold_q) begin
                check("hold_valid", 32'(evt_valid), 32'd1);
                check("hold_pad", 32'(evt_pad), 32'(hold_pad));
                check("hold_press", 32'(evt_press), 32'(hold_press));
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got pad %0d press %0d expected none",
                             evt_pad, evt_press);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_pad", 32'(evt_pad), 32'(e[2:1]));
                    check("evt_press", 32'(evt_press), 32'(e[0]));
                end
            end
            hold_q     = evt_valid && !evt_ready;
            hold_pad   = evt_pad;
            hold_press = evt_press;
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        rst       = 1'b1;
        pad_i     = 4'b0000;
        evt_ready = 1'b1;
        ovf_clear = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Clean press and release on pad 2
        pad_i[2] = 1'b1;
        push(2'd2, 1'b1);
        repeat (9) tick();
        check("press_state_early", 32'(state_o[2]), 32'd0);
        tick();
        check("press_state", 32'(state_o[2]), 32'd1);
        tick();
        check("press_valid", 32'(evt_valid), 32'd1);
        check("press_pad", 32'(evt_pad), 32'd2);
        check("press_kind", 32'(evt_press), 32'd1);
        tick();
        check("press_one_cycle", 32'(evt_valid), 32'd0);
        pad_i[2] = 1'b0;
        push(2'd2, 1'b0);
        repeat (12) tick();
        check("release_state", 32'(state_o), 32'd0);

        // Glitch rejection on pad 1: 7 high, 1 low, then held high
        pad_i[1] = 1'b1;
        repeat (7) tick();
        pad_i[1] = 1'b0;
        tick();
        pad_i[1] = 1'b1;
        push(2'd1, 1'b1);
        repeat (9) tick();
        check("glitch_state_early", 32'(state_o[1]), 32'd0);
        check("glitch_no_evt", 32'(evt_valid), 32'd0);
        tick();
        check("glitch_state", 32'(state_o[1]), 32'd1);
        tick();
        check("glitch_valid", 32'(evt_valid), 32'd1);
        pad_i[1] = 1'b0;
        push(2'd1, 1'b0);
        repeat (12) tick();

        // Simultaneous rise on pads 0 and 3
        pad_i[0] = 1'b1;
        pad_i[3] = 1'b1;
        push(2'd0, 1'b1);
        push(2'd3, 1'b1);
        repeat (11) tick();
        check("sim_first_valid", 32'(evt_valid), 32'd1);
        check("sim_first_pad", 32'(evt_pad), 32'd0);
        tick();
        check("sim_second_valid", 32'(evt_valid), 32'd1);
        check("sim_second_pad", 32'(evt_pad), 32'd3);
        tick();
        check("sim_done", 32'(evt_valid), 32'd0);
        check("sim_no_ovf", 32'(overflow_o), 32'd0);
        pad_i[0] = 1'b0;
        pad_i[3] = 1'b0;
        push(2'd0, 1'b0);
        push(2'd3, 1'b0);
        repeat (14) tick();

        // Backpressure and overflow
        evt_ready = 1'b0;
        pad_i[1]  = 1'b1;
        push(2'd1, 1'b1);
        repeat (11) tick();
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_pad", 32'(evt_pad), 32'd1);
        check("bp_press", 32'(evt_press), 32'd1);
        pad_i[2] = 1'b1;
        repeat (12) tick();
        pad_i[1] = 1'b0;        // pend[1] was drained, so no merge yet
        repeat (12) tick();
        check("bp_no_ovf_yet", 32'(overflow_o), 32'd0);
        pad_i[1] = 1'b1;        // merges into pending pad-1 release
        repeat (12) tick();
        check("bp_ovf_set", 32'(overflow_o), 32'd1);
        pad_i[1] = 1'b0;        // merges again, newest level is release
        repeat (12) tick();
        check("bp_ovf_sticky", 32'(overflow_o), 32'd1);
        check("bp_state", 32'(state_o), 32'b0100);
        push(2'd1, 1'b0);
        push(2'd2, 1'b1);
        evt_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained", 32'(evt_valid), 32'd0);
        check("bp_ovf_before_clr", 32'(overflow_o), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        pad_i[2] = 1'b0;
        push(2'd2, 1'b0);
        repeat (14) tick();

        // Reset mid-debounce with pad 0 held
        pad_i[0] = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_idle("midrst");
        rst = 1'b0;
        push(2'd0, 1'b1);
        repeat (10) tick();
        check("midrst_no_evt", 32'(evt_valid), 32'd0);
        tick();
        check("midrst_valid", 32'(evt_valid), 32'd1);
        check("midrst_pad", 32'(evt_pad), 32'd0);
        check("midrst_press", 32'(evt_press), 32'd1);
        pad_i[0] = 1'b0;
        push(2'd0, 1'b0);
        repeat (14) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
